// File: rtl/dab_pkg.sv
// Shared types and constants for the dual-active-bridge modulator and the
// downstream deadtime/gate-drive stage.
package dab_pkg;

    localparam int unsigned W_DEFAULT = 16;

    // Three-level bridge command; 2'b10 is never produced.
    typedef logic signed [1:0] level_t;

    localparam level_t LVL_POS  = 2'sb01;
    localparam level_t LVL_ZERO = 2'sb00;
    localparam level_t LVL_NEG  = 2'sb11;

endpackage

// File: rtl/dab_modulator_if.sv
// Settings and level-command bundle between the controller and the modulator.
interface dab_modulator_if
    import dab_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) ();

    logic         CE;
    logic         en;
    logic [W-1:0] half_period;
    logic [W-1:0] phase;
    logic [W-1:0] d1;
    logic [W-1:0] d2;
    level_t       V1;
    level_t       V2;
    logic         sync;

    modport master (
        output CE, en, half_period, phase, d1, d2,
        input  V1, V2, sync
    );

    modport slave (
        input  CE, en, half_period, phase, d1, d2,
        output V1, V2, sync
    );

endinterface

// File: rtl/dab_level_gen.sv
// Three-level waveform lookup: zero for d ticks at the start of each half-cycle,
// +1 for the rest of the first half, -1 for the rest of the second half.
module dab_level_gen
    import dab_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic [W:0]   q_i,
    input  logic [W-1:0] d_i,
    input  logic [W-1:0] n_i,
    output level_t       level_c_o
);

    localparam int unsigned CW = W + 1;

    logic [W:0] n_ext;
    logic [W:0] d_ext;
    logic [W:0] nd;

    assign n_ext = {1'b0, n_i};
    assign d_ext = {1'b0, d_i};
    assign nd    = CW'(n_ext + d_ext);

    always_comb begin
        level_c_o = LVL_NEG;
        if (q_i < d_ext) begin
            level_c_o = LVL_ZERO;
        end else if (q_i < n_ext) begin
            level_c_o = LVL_POS;
        end else if (q_i < nd) begin
            level_c_o = LVL_ZERO;
        end
    end

endmodule

// File: rtl/dab_modulator.sv
// Phase-shift modulator: shared carrier counter with double-buffered settings
// that only swap at the carrier wrap, driving V1/V2 level commands and sync.
module dab_modulator
    import dab_pkg::*;
#(
    parameter int unsigned W = W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    dab_modulator_if.slave   bus
);

    localparam int unsigned CW = W + 1;

    logic [W:0]   cnt_q,  cnt_d;
    logic [W-1:0] n_q,    n_d;
    logic [W-1:0] ph_q,   ph_d;
    logic [W-1:0] d1_q,   d1_d;
    logic [W-1:0] d2_q,   d2_d;
    level_t       v1_q,   v1_d;
    level_t       v2_q,   v2_d;
    logic         sync_q, sync_d;

    logic [W:0]   two_n;
    logic [W:0]   last_pos;
    logic         run;
    logic         wrap;
    logic         load;

    logic [W:0]   in_last;
    logic [W-1:0] ph_clamp;
    logic [W-1:0] d1_clamp;
    logic [W-1:0] d2_clamp;

    logic [W:0]   ph_ext;
    logic [W+1:0] p2_wide;
    logic [W:0]   p2;

    level_t       lvl1_c;
    level_t       lvl2_c;

    assign two_n    = {n_q, 1'b0};
    assign last_pos = CW'(two_n - CW'(1));
    assign run      = bus.en && (n_q >= W'(2));
    assign wrap     = (cnt_q == last_pos);
    assign load     = !run || wrap;

    // Clamp against the incoming half-period, since that is what gets latched with them.
    assign in_last  = CW'({bus.half_period, 1'b0} - CW'(1));
    assign ph_clamp = ({1'b0, bus.phase} > in_last) ? W'(in_last) : bus.phase;
    assign d1_clamp = (bus.d1 > bus.half_period) ? bus.half_period : bus.d1;
    assign d2_clamp = (bus.d2 > bus.half_period) ? bus.half_period : bus.d2;

    // V2 position is V1 position minus the lag, wrapped into 0..2N-1.
    assign ph_ext  = {1'b0, ph_q};
    assign p2_wide = (W+2)'({1'b0, cnt_q} + {1'b0, two_n} - {2'b00, ph_q});
    assign p2      = (cnt_q >= ph_ext) ? CW'(cnt_q - ph_ext) : CW'(p2_wide);

    dab_level_gen #(.W(W)) u_lvl1 (
        .q_i       (cnt_q),
        .d_i       (d1_q),
        .n_i       (n_q),
        .level_c_o (lvl1_c)
    );

    dab_level_gen #(.W(W)) u_lvl2 (
        .q_i       (p2),
        .d_i       (d2_q),
        .n_i       (n_q),
        .level_c_o (lvl2_c)
    );

    always_comb begin
        n_d    = n_q;
        ph_d   = ph_q;
        d1_d   = d1_q;
        d2_d   = d2_q;
        cnt_d  = '0;
        v1_d   = LVL_ZERO;
        v2_d   = LVL_ZERO;
        sync_d = 1'b0;

        if (load) begin
            n_d  = bus.half_period;
            ph_d = ph_clamp;
            d1_d = d1_clamp;
            d2_d = d2_clamp;
        end

        if (run) begin
            cnt_d  = wrap ? '0 : CW'(cnt_q + CW'(1));
            v1_d   = lvl1_c;
            v2_d   = lvl2_c;
            sync_d = (cnt_q == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            n_q    <= '0;
            ph_q   <= '0;
            d1_q   <= '0;
            d2_q   <= '0;
            v1_q   <= LVL_ZERO;
            v2_q   <= LVL_ZERO;
            sync_q <= 1'b0;
        end else if (bus.CE) begin
            cnt_q  <= cnt_d;
            n_q    <= n_d;
            ph_q   <= ph_d;
            d1_q   <= d1_d;
            d2_q   <= d2_d;
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            sync_q <= sync_d;
        end
    end

    assign bus.V1   = v1_q;
    assign bus.V2   = v2_q;
    assign bus.sync = sync_q;

endmodule

// File: tb/tb_dab_modulator.sv
// Scoreboard bench for dab_modulator: directed per-edge expectations are queued
// by the driver and checked by an independent monitor after each clock edge.
module tb_dab_modulator;
    import dab_pkg::*;

    localparam int unsigned W = W_DEFAULT;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dab_modulator_if #(.W(W)) bus ();

    dab_modulator #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int    v1;
        int    v2;
        int    sync;
        string tag;
    } exp_t;

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Hand-derived level sequences for N=4, positions 0..7.
    int pat0 [8] = '{ 1,  1,  1,  1, -1, -1, -1, -1};
    int lag2 [8] = '{-1, -1,  1,  1,  1,  1, -1, -1};
    int d1p  [8] = '{ 0,  1,  1,  1,  0, -1, -1, -1};
    int lag3 [8] = '{-1, -1, -1,  1,  1,  1,  1, -1};

    function automatic int lvl(input logic [1:0] x);
        logic signed [1:0] s;
        s = x;
        return int'(s);
    endfunction

    task automatic check_now(input int e1, input int e2, input int es, input string tag);
        n_vec++;
        if (lvl(bus.V1) != e1 || lvl(bus.V2) != e2 || int'(bus.sync) != es) begin
            n_err++;
            $display("FAIL %s: got V1=%0d V2=%0d sync=%0d, want V1=%0d V2=%0d sync=%0d",
                     tag, lvl(bus.V1), lvl(bus.V2), bus.sync, e1, e2, es);
        end
    endtask

    task automatic drive(input bit ce, input bit en, input int e1, input int e2,
                         input int es, input string tag);
        @(negedge clk);
        bus.CE = ce;
        bus.en = en;
        sbq.push_back('{e1, e2, es, tag});
    endtask

    task automatic set_cfg(input int n, input int ph, input int a, input int b);
        bus.half_period = W'(n);
        bus.phase       = W'(ph);
        bus.d1          = W'(a);
        bus.d2          = W'(b);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sbq.size() > 0; i++) @(posedge clk);
        #2;
        if (sbq.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d pending, want 0", sbq.size());
            sbq.delete();
        end
    endtask

    // Monitor: one expectation per clock edge once the driver has queued it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check_now(e.v1, e.v2, e.sync, e.tag);
            end
        end
    end

    initial begin
        rst    = 1'b1;
        bus.CE = 1'b0;
        bus.en = 1'b0;
        set_cfg(0, 0, 0, 0);
        #2;
        check_now(0, 0, 0, "reset_state");
        #20;
        @(negedge clk);
        rst = 1'b0;

        // Basic carrier, no phase shift, no zero interval.
        drive(1, 0, 0, 0, 0, "t1_idle");
        set_cfg(4, 0, 0, 0);
        for (int k = 0; k < 16; k++)
            drive(1, 1, pat0[k % 8], pat0[k % 8], int'(k % 8 == 0), "t1_run");

        // Phase lag of 2 ticks.
        drive(1, 0, 0, 0, 0, "t2_idle");
        set_cfg(4, 2, 0, 0);
        for (int k = 0; k < 8; k++)
            drive(1, 1, pat0[k], lag2[k], int'(k == 0), "t2_lag2");

        // V1 zero interval of 1, then d1=9 clamped to N gives all-zero V1.
        drive(1, 0, 0, 0, 0, "t3_idle");
        set_cfg(4, 0, 1, 0);
        for (int k = 0; k < 24; k++) begin
            drive(1, 1, (k < 16) ? d1p[k % 8] : 0, pat0[k % 8], int'(k % 8 == 0), "t3_duty");
            if (k == 8) bus.d1 = W'(9);
        end

        // Phase change mid-period only takes effect after the wrap.
        drive(1, 0, 0, 0, 0, "t4_idle");
        set_cfg(4, 0, 0, 0);
        for (int k = 0; k < 16; k++) begin
            drive(1, 1, pat0[k % 8], (k < 8) ? pat0[k % 8] : lag3[k % 8],
                  int'(k % 8 == 0), "t4_phchg");
            if (k == 5) bus.phase = W'(3);
        end

        // en drops at position 3: immediate idle, no period completion.
        for (int k = 0; k < 4; k++)
            drive(1, 1, pat0[k], lag3[k], int'(k == 0), "t5_run");
        drive(1, 0, 0, 0, 0, "t5_enoff");

        // 50% CE: each position held for two clocks.
        for (int k = 0; k < 16; k++)
            drive(k % 2 == 0, 1, pat0[k / 2], lag3[k / 2], int'(k / 2 == 0), "t5_ce50");

        // Async reset mid-period, no clock edge needed.
        drive(1, 1, pat0[0], lag3[0], 1, "t6_run");
        drive(1, 1, pat0[1], lag3[1], 0, "t6_run");
        drain();
        rst = 1'b1;
        #1;
        check_now(0, 0, 0, "t6_async_rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // N=1 is invalid: stays idle, sync never pulses.
        set_cfg(1, 0, 0, 0);
        for (int k = 0; k < 12; k++)
            drive(1, 1, 0, 0, 0, "t6_n1");
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dab_modulator.md
Name: dab_modulator

Overview:
Phase-shift modulator for the dual-active-bridge converter. It generates the three-level primary and secondary bridge voltage commands (V1, V2; signed 2-bit, values +1/0/-1) from a shared carrier counter.
It sits directly upstream of the deadtime/gate-drive stage, which consumes V1/V2 under the same CE.
Settings are double-buffered and take effect only at a carrier period boundary, so a period is never torn.

Parameters:
W, 16, width of period/phase/duty settings in clock ticks (carrier counter is W+1 bits)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
CE  in  1  clock enable; all state advances only on edges with CE=1
en  in  1  modulator run; 0 = idle (outputs zero, counter cleared)
half_period  in  W  N = ticks per carrier half-cycle
phase  in  W  V2 lag behind V1, ticks, range 0..2N-1
d1  in  W  zero-interval width at start of each V1 half-cycle, ticks
d2  in  W  same for V2
V1  out  2 (signed)  primary bridge level command
V2  out  2 (signed)  secondary bridge level command
sync  out  1  one-tick pulse at carrier position 0 (V1 period start)

Behaviour:
- rst: cnt=0, all shadow registers=0, V1=0, V2=0, sync=0, independent of clk/CE. Mid-operation reset forces outputs to 0 immediately.
- CE=0 edges: all registers hold.
- Shadow registers: N_s, ph_s, d1_s, d2_s.
  - Load from inputs on every CE edge with en=0.
  - With en=1, load only on the CE edge where cnt==2N_s-1. New values apply from position 0.
- Load-time clamping, using the incoming N:
  - ph_s = min(phase, 2N-1)
  - d1_s = min(d1, N), d2_s = min(d2, N)
- Idle (en=0, or N_s<2):
  - cnt<=0, V1<=0, V2<=0, sync<=0.
  - If en=1 but N_s<2, shadows keep loading each CE edge, so the modulator starts once a valid N is applied.
- Run (en=1, N_s>=2), on each CE edge, with p = current cnt:
  - V1 <= L(p, d1_s).
  - V2 <= L(p2, d2_s), where p2 = p - ph_s if p >= ph_s, else p + 2N_s - ph_s.
  - sync <= (p==0).
  - cnt <= (p==2N_s-1) ? 0 : p+1.
- Level function L(q,d):
  - q<d gives 0
  - d<=q<N gives +1
  - N<=q<N+d gives 0
  - N+d<=q<2N gives -1
- Level encoding: +1=2'b01, 0=2'b00, -1=2'b11. Code 2'b10 is never produced.
- Latency: outputs for position p are visible after the same edge that advances cnt past p. The first enabled CE edge presents position 0 (sync=1).
- en falling mid-period: next CE edge forces outputs 0 and cnt 0. There is no completion of the period.
- d=N: output is permanently 0. ph=0 gives V2 identical to V1 when d1=d2.
- Simultaneous wrap and input change: values sampled at the wrap edge are used.

Decomposition:
- Package dab_pkg holds:
  - LVL_POS=2'sb01, LVL_ZERO=2'sb00, LVL_NEG=2'sb11
  - default W
  - the level type, shared with the deadtime/gate-drive stage
- One combinational sub-module, dab_level_gen, is natural. Inputs: q, d, N. Output: level. It is instantiated twice (V1 and V2).
- Counter, shadow registers, clamping and phase subtraction stay in the top.

Test Plan:
1. rst, then N=4, ph=0, d1=d2=0, en=1, CE=1 -> V1=V2 sequence +1,+1,+1,+1,-1,-1,-1,-1 repeating; sync=1 on the first of every 8.
2. N=4, ph=2, d=0 -> V2 lags V1 by 2 ticks: V2 = -1,-1,+1,+1,+1,+1,-1,-1 aligned with V1 period start.
3. N=4, d1=1 -> V1 = 0,+1,+1,+1,0,-1,-1,-1. Then d1=9 (clamps to 4) -> V1 all 0 from the next period.
4. Change ph 0->3 at position 5 -> V2 unchanged until after the position-7 edge; lag is 3 from the next sync.
5. en low at position 3 -> next CE edge V1=V2=0, sync=0. Toggle CE at 50% -> each position lasts 2 clk.
6. Assert rst asynchronously mid-period -> outputs 0 without a clock edge. Also N=1 with en=1 -> outputs stay 0, sync never pulses.
